// File: rtl/imem_arbiter_if.sv
// Bus bundle for imem_arbiter: fetch request/response, loader request/response, SRAM side.
// Latency: none (wires only); read data returns one cycle after the accepting edge.
// Backpressure: req is held until gnt; responses cannot be stalled.
//
// Modports:
//   slave  - the arbiter: takes fetch/loader requests and mem_rdata, drives grants, responses and SRAM controls.
//   master - the surroundings: fetch stage, loader and the SRAM model.
interface imem_arbiter_if #(
   parameter int DATA_WIDTH      = 32,
   parameter int IMEM_ADDR_WIDTH = 10
);
   // fetch port
   logic                       f_req;
   logic [IMEM_ADDR_WIDTH-1:0] f_addr;
   logic                       f_flush;
   logic                       f_gnt;
   logic                       f_rvalid;
   logic [DATA_WIDTH-1:0]      f_rdata;

   // loader / debug port
   logic                       l_req;
   logic                       l_we;
   logic [IMEM_ADDR_WIDTH-1:0] l_addr;
   logic [DATA_WIDTH-1:0]      l_wdata;
   logic                       l_gnt;
   logic                       l_rvalid;
   logic [DATA_WIDTH-1:0]      l_rdata;

   // single-port synchronous-read SRAM
   logic                       mem_en;
   logic                       mem_we;
   logic [IMEM_ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0]      mem_wdata;
   logic [DATA_WIDTH-1:0]      mem_rdata;

   modport slave (
      input  f_req, f_addr, f_flush,
      output f_gnt, f_rvalid, f_rdata,
      input  l_req, l_we, l_addr, l_wdata,
      output l_gnt, l_rvalid, l_rdata,
      output mem_en, mem_we, mem_addr, mem_wdata,
      input  mem_rdata
   );

   modport master (
      output f_req, f_addr, f_flush,
      input  f_gnt, f_rvalid, f_rdata,
      output l_req, l_we, l_addr, l_wdata,
      input  l_gnt, l_rvalid, l_rdata,
      input  mem_en, mem_we, mem_addr, mem_wdata,
      output mem_rdata
   );
endinterface

// File: rtl/imem_arbiter.sv
// Arbitrates one single-port instruction SRAM between pipeline fetch and a loader/debug port.
// Latency: grant is combinational; read data returns exactly one cycle after acceptance, writes have no response.
// Backpressure: loader wins ties, but after MAX_LDR_BURST loader grants with fetch waiting, fetch is granted.
//
// Ports:
//   clk    - clock
//   rst_n  - asynchronous active-low reset; grants and SRAM enables are forced low while asserted
//   bus    - imem_arbiter_if.slave: f_* fetch port, l_* loader port, mem_* SRAM port
module imem_arbiter #(
   parameter int DATA_WIDTH      = 32,
   parameter int IMEM_ADDR_WIDTH = 10,
   parameter int MAX_LDR_BURST   = 4     // legal range 1..15 (fits the 4-bit burst counter)
) (
   input  logic          clk,
   input  logic          rst_n,
   imem_arbiter_if.slave bus
);

   // Who the SRAM read data returning next cycle belongs to.
   typedef enum logic [1:0] {
      OWN_NONE   = 2'd0,
      OWN_FETCH  = 2'd1,
      OWN_LOADER = 2'd2
   } owner_e;

   localparam logic [3:0] BURST_MAX = 4'(MAX_LDR_BURST);

   owner_e     owner_q, owner_d;
   logic [3:0] burst_q, burst_d;
   logic       f_gnt_c, l_gnt_c;
   logic       ldr_wins;

   // State registers. An asynchronous reset drops any response that was in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         owner_q <= OWN_NONE;
         burst_q <= 4'd0;
      end else begin
         owner_q <= owner_d;
         burst_q <= burst_d;
      end
   end

   // Grant decision, response ownership and burst counting.
   always_comb begin
      f_gnt_c = 1'b0;
      l_gnt_c = 1'b0;
      owner_d = OWN_NONE;
      burst_d = 4'd0;

      // Loader has priority unless fetch has already sat through a full burst.
      ldr_wins = bus.l_req && (!bus.f_req || (burst_q < BURST_MAX));

      // Grants are gated with rst_n so nothing reaches the SRAM during reset.
      if (rst_n) begin
         if (ldr_wins) begin
            l_gnt_c = 1'b1;
         end else if (bus.f_req) begin
            f_gnt_c = 1'b1;
         end
      end

      // Only reads produce a response; a write or an idle cycle leaves no owner.
      if (f_gnt_c) begin
         owner_d = OWN_FETCH;
      end else if (l_gnt_c && !bus.l_we) begin
         owner_d = OWN_LOADER;
      end

      // Count loader grants only while fetch is actually waiting; a fetch grant
      // or fetch going quiet restarts the count.
      if (l_gnt_c && bus.f_req) begin
         if (burst_q < BURST_MAX) begin
            burst_d = 4'(burst_q + 4'd1);
         end else begin
            burst_d = burst_q;
         end
      end
   end

   // SRAM drive: fetch is always a read; write data is zeroed unless the loader writes.
   assign bus.mem_en    = f_gnt_c | l_gnt_c;
   assign bus.mem_we    = l_gnt_c & bus.l_we;
   assign bus.mem_addr  = l_gnt_c ? bus.l_addr : bus.f_addr;
   assign bus.mem_wdata = (l_gnt_c & bus.l_we) ? bus.l_wdata : {DATA_WIDTH{1'b0}};

   assign bus.f_gnt = f_gnt_c;
   assign bus.l_gnt = l_gnt_c;

   // f_flush kills only the fetch response returning this cycle; it never
   // blocks a new fetch grant and never touches a loader response.
   assign bus.f_rvalid = (owner_q == OWN_FETCH) && !bus.f_flush;
   assign bus.l_rvalid = (owner_q == OWN_LOADER);

   // Read data fans out to both ports; rvalid says whose it is.
   assign bus.f_rdata = bus.mem_rdata;
   assign bus.l_rdata = bus.mem_rdata;

endmodule

// File: tb/tb_imem_arbiter.sv
module tb_imem_arbiter;
   localparam int DW    = 32;
   localparam int AW    = 10;
   localparam int MAXB  = 4;
   localparam int DEPTH = 1 << AW;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   imem_arbiter_if #(.DATA_WIDTH(DW), .IMEM_ADDR_WIDTH(AW)) bus ();

   imem_arbiter #(
      .DATA_WIDTH      (DW),
      .IMEM_ADDR_WIDTH (AW),
      .MAX_LDR_BURST   (MAXB)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   logic [DW-1:0] mem     [DEPTH];
   logic [DW-1:0] ref_mem [DEPTH];
   logic [DW-1:0] mem_rdata_q;
   int checks   = 0;
   int failures = 0;

   function automatic logic [DW-1:0] mem_init(int i);
      return (32'h9E37_79B9 * 32'(i + 1)) ^ 32'h1234_0000;
   endfunction

   function automatic logic [AW-1:0] rand_addr();
      logic [AW-1:0] a;
      a = AW'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) a = ~a;   // top of the address space
      return a;
   endfunction

   // Synchronous-read single-port SRAM (environment, not the reference)
   assign bus.mem_rdata = mem_rdata_q;
   initial begin
      for (int i = 0; i < DEPTH; i++) mem[i] = mem_init(i);
      forever begin
         @(posedge clk);
         if (bus.mem_en === 1'b1) begin
            if (bus.mem_we === 1'b1) mem[bus.mem_addr] <= bus.mem_wdata;
            else                     mem_rdata_q <= mem[bus.mem_addr];
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic idle_inputs();
      bus.f_req   = 1'b0;
      bus.f_addr  = '0;
      bus.f_flush = 1'b0;
      bus.l_req   = 1'b0;
      bus.l_we    = 1'b0;
      bus.l_addr  = '0;
      bus.l_wdata = '0;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      idle_inputs();
      repeat (2) next_cycle();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      idle_inputs();
      bus.f_req = 1'b1;
      bus.l_req = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++; if (bus.f_gnt !== 1'b0)    begin failures++; $display("FAIL reset_f_gnt: got %b expected 0", bus.f_gnt); end
      checks++; if (bus.l_gnt !== 1'b0)    begin failures++; $display("FAIL reset_l_gnt: got %b expected 0", bus.l_gnt); end
      checks++; if (bus.mem_en !== 1'b0)   begin failures++; $display("FAIL reset_mem_en: got %b expected 0", bus.mem_en); end
      checks++; if (bus.mem_we !== 1'b0)   begin failures++; $display("FAIL reset_mem_we: got %b expected 0", bus.mem_we); end
      checks++; if (bus.f_rvalid !== 1'b0) begin failures++; $display("FAIL reset_f_rvalid: got %b expected 0", bus.f_rvalid); end
      checks++; if (bus.l_rvalid !== 1'b0) begin failures++; $display("FAIL reset_l_rvalid: got %b expected 0", bus.l_rvalid); end
      rst_n = 1'b1;
      #1;
      checks++; if (bus.l_gnt !== 1'b1) begin failures++; $display("FAIL release_l_gnt: got %b expected 1", bus.l_gnt); end
      checks++; if (bus.f_gnt !== 1'b0) begin failures++; $display("FAIL release_f_gnt: got %b expected 0", bus.f_gnt); end
      next_cycle();                      // loader read of addr 0 accepted
      idle_inputs();
      @(negedge clk);
      checks++; if (bus.l_rvalid !== 1'b1) begin failures++; $display("FAIL release_l_rvalid: got %b expected 1", bus.l_rvalid); end
      checks++; if (bus.l_rdata !== ref_mem[0]) begin failures++; $display("FAIL release_l_rdata: got %h expected %h", bus.l_rdata, ref_mem[0]); end
      next_cycle();
      drain();
   endtask

   task automatic test_fetch_stream();
      logic [DW-1:0] words [3];
      words[0] = 32'h0000_0013;
      words[1] = 32'h0010_0093;
      words[2] = 32'h0020_0113;
      // preload through the loader port
      for (int i = 0; i < 3; i++) begin
         bus.l_req = 1'b1; bus.l_we = 1'b1; bus.l_addr = AW'(i); bus.l_wdata = words[i];
         @(negedge clk);
         checks++; if (bus.l_gnt !== 1'b1 || bus.mem_we !== 1'b1) begin failures++; $display("FAIL preload_we[%0d]: got gnt=%b we=%b expected 1/1", i, bus.l_gnt, bus.mem_we); end
         checks++; if (bus.mem_addr !== AW'(i) || bus.mem_wdata !== words[i]) begin failures++; $display("FAIL preload_bus[%0d]: got %h/%h expected %h/%h", i, bus.mem_addr, bus.mem_wdata, AW'(i), words[i]); end
         next_cycle();
         ref_mem[i] = words[i];
      end
      idle_inputs();
      next_cycle();
      for (int c = 0; c < 4; c++) begin
         bus.f_req  = (c < 3);
         bus.f_addr = AW'(c % 3);
         @(negedge clk);
         if (c < 3) begin
            checks++; if (bus.f_gnt !== 1'b1 || bus.mem_we !== 1'b0) begin failures++; $display("FAIL fetch_gnt[%0d]: got gnt=%b we=%b expected 1/0", c, bus.f_gnt, bus.mem_we); end
         end
         if (c > 0) begin
            checks++; if (bus.f_rvalid !== 1'b1 || bus.f_rdata !== words[c-1]) begin failures++; $display("FAIL fetch_rdata[%0d]: got v=%b %h expected 1 %h", c, bus.f_rvalid, bus.f_rdata, words[c-1]); end
         end else begin
            checks++; if (bus.f_rvalid !== 1'b0) begin failures++; $display("FAIL fetch_rvalid0: got %b expected 0", bus.f_rvalid); end
         end
         next_cycle();
      end
      drain();
   endtask

   task automatic test_loader_wr_rd();
      bus.l_req = 1'b1; bus.l_we = 1'b1; bus.l_addr = AW'(5); bus.l_wdata = 32'hDEAD_BEEF;
      @(negedge clk);
      checks++; if (bus.l_gnt !== 1'b1 || bus.mem_we !== 1'b1) begin failures++; $display("FAIL ldr_write: got gnt=%b we=%b expected 1/1", bus.l_gnt, bus.mem_we); end
      next_cycle();
      ref_mem[5] = 32'hDEAD_BEEF;
      bus.l_we = 1'b0;
      @(negedge clk);
      checks++; if (bus.l_rvalid !== 1'b0) begin failures++; $display("FAIL ldr_write_noresp: got %b expected 0", bus.l_rvalid); end
      checks++; if (bus.l_gnt !== 1'b1 || bus.mem_we !== 1'b0) begin failures++; $display("FAIL ldr_read_gnt: got gnt=%b we=%b expected 1/0", bus.l_gnt, bus.mem_we); end
      next_cycle();
      idle_inputs();
      @(negedge clk);
      checks++; if (bus.l_rvalid !== 1'b1 || bus.l_rdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL ldr_readback: got v=%b %h expected 1 deadbeef", bus.l_rvalid, bus.l_rdata); end
      next_cycle();
      drain();
   endtask

   task automatic test_starvation();
      logic exp_f, prev_f;
      prev_f = 1'b0;
      bus.l_req = 1'b1; bus.l_we = 1'b0; bus.l_addr = AW'(7);
      bus.f_req = 1'b1; bus.f_addr = AW'(11);
      for (int i = 0; i < 2 * (MAXB + 1); i++) begin
         exp_f = ((i % (MAXB + 1)) == MAXB);
         @(negedge clk);
         checks++; if (bus.f_gnt !== exp_f || bus.l_gnt !== !exp_f) begin failures++; $display("FAIL starve_pattern[%0d]: got f=%b l=%b expected f=%b l=%b", i, bus.f_gnt, bus.l_gnt, exp_f, !exp_f); end
         if (i > 0) begin
            checks++;
            if (bus.f_rvalid !== prev_f || bus.l_rvalid !== !prev_f ||
                (prev_f ? bus.f_rdata !== ref_mem[11] : bus.l_rdata !== ref_mem[7])) begin
               failures++;
               $display("FAIL starve_resp[%0d]: got fv=%b lv=%b fd=%h ld=%h expected fetch_owner=%b", i, bus.f_rvalid, bus.l_rvalid, bus.f_rdata, bus.l_rdata, prev_f);
            end
         end
         prev_f = exp_f;
         next_cycle();
      end
      drain();
   endtask

   task automatic test_flush();
      bus.f_req = 1'b1; bus.f_addr = AW'(3);
      @(negedge clk);
      checks++; if (bus.f_gnt !== 1'b1) begin failures++; $display("FAIL flush_first_gnt: got %b expected 1", bus.f_gnt); end
      next_cycle();
      bus.f_addr = AW'(8); bus.f_flush = 1'b1;
      @(negedge clk);
      checks++; if (bus.f_gnt !== 1'b1) begin failures++; $display("FAIL flush_target_gnt: got %b expected 1", bus.f_gnt); end
      checks++; if (bus.f_rvalid !== 1'b0) begin failures++; $display("FAIL flush_suppress: got %b expected 0", bus.f_rvalid); end
      next_cycle();
      idle_inputs();
      @(negedge clk);
      checks++; if (bus.f_rvalid !== 1'b1 || bus.f_rdata !== ref_mem[8]) begin failures++; $display("FAIL flush_target_resp: got v=%b %h expected 1 %h", bus.f_rvalid, bus.f_rdata, ref_mem[8]); end
      next_cycle();
      bus.l_req = 1'b1; bus.l_we = 1'b0; bus.l_addr = AW'(9);
      next_cycle();
      idle_inputs();
      bus.f_flush = 1'b1;
      @(negedge clk);
      checks++; if (bus.l_rvalid !== 1'b1 || bus.l_rdata !== ref_mem[9]) begin failures++; $display("FAIL flush_ldr_unaffected: got v=%b %h expected 1 %h", bus.l_rvalid, bus.l_rdata, ref_mem[9]); end
      checks++; if (bus.f_rvalid !== 1'b0) begin failures++; $display("FAIL flush_ldr_f_rvalid: got %b expected 0", bus.f_rvalid); end
      next_cycle();
      drain();
   endtask

   task automatic test_reset_mid_read();
      bus.l_req = 1'b1; bus.l_we = 1'b0; bus.l_addr = AW'(5);
      next_cycle();                      // read accepted
      idle_inputs();
      checks++; if (bus.l_rvalid !== 1'b1) begin failures++; $display("FAIL midrst_pre: got %b expected 1", bus.l_rvalid); end
      #1 rst_n = 1'b0;
      #1;
      checks++; if (bus.l_rvalid !== 1'b0) begin failures++; $display("FAIL midrst_during: got %b expected 0", bus.l_rvalid); end
      #1 rst_n = 1'b1;
      @(negedge clk);
      checks++; if (bus.l_rvalid !== 1'b0) begin failures++; $display("FAIL midrst_after: got %b expected 0", bus.l_rvalid); end
      next_cycle();
      @(negedge clk);
      checks++; if (bus.l_rvalid !== 1'b0 || bus.f_rvalid !== 1'b0) begin failures++; $display("FAIL midrst_later: got l=%b f=%b expected 0/0", bus.l_rvalid, bus.f_rvalid); end
      next_cycle();
   endtask

   // Random traffic against a transaction-level model: one memory op per cycle,
   // loader preferred unless fetch has already waited through MAXB loader grants.
   task automatic test_random(int n);
      int            waited;
      int            pend;       // 0 none, 1 fetch, 2 loader
      logic [DW-1:0] pend_data;
      logic          exp_f, exp_l, f_acc, l_acc;
      waited = 0; pend = 0; pend_data = '0; f_acc = 1'b0; l_acc = 1'b0;
      idle_inputs();
      for (int cyc = 0; cyc < n; cyc++) begin
         if (!bus.f_req || f_acc) begin
            bus.f_req  = ($urandom_range(0, 3) != 0);
            bus.f_addr = rand_addr();
         end
         if (!bus.l_req || l_acc) begin
            bus.l_req   = ($urandom_range(0, 3) != 0);
            bus.l_we    = $urandom_range(0, 1) == 1;
            bus.l_addr  = rand_addr();
            bus.l_wdata = $urandom();
         end
         bus.f_flush = ($urandom_range(0, 4) == 0);
         exp_l = bus.l_req && (!bus.f_req || waited < MAXB);
         exp_f = bus.f_req && !exp_l;
         @(negedge clk);
         checks++; if (bus.f_gnt !== exp_f || bus.l_gnt !== exp_l) begin failures++; $display("FAIL rand_gnt[%0d]: got f=%b l=%b expected f=%b l=%b", cyc, bus.f_gnt, bus.l_gnt, exp_f, exp_l); end
         checks++; if (bus.mem_en !== (exp_f | exp_l) || bus.mem_we !== (exp_l & bus.l_we)) begin failures++; $display("FAIL rand_mem_ctl[%0d]: got en=%b we=%b expected en=%b we=%b", cyc, bus.mem_en, bus.mem_we, exp_f | exp_l, exp_l & bus.l_we); end
         if (exp_f || exp_l) begin
            checks++; if (bus.mem_addr !== (exp_l ? bus.l_addr : bus.f_addr)) begin failures++; $display("FAIL rand_mem_addr[%0d]: got %h expected %h", cyc, bus.mem_addr, exp_l ? bus.l_addr : bus.f_addr); end
            checks++; if (bus.mem_wdata !== ((exp_l && bus.l_we) ? bus.l_wdata : '0)) begin failures++; $display("FAIL rand_mem_wdata[%0d]: got %h expected %h", cyc, bus.mem_wdata, (exp_l && bus.l_we) ? bus.l_wdata : '0); end
         end
         checks++; if (bus.f_rvalid !== (pend == 1 && !bus.f_flush)) begin failures++; $display("FAIL rand_f_rvalid[%0d]: got %b expected %b", cyc, bus.f_rvalid, pend == 1 && !bus.f_flush); end
         checks++; if (bus.l_rvalid !== (pend == 2)) begin failures++; $display("FAIL rand_l_rvalid[%0d]: got %b expected %b", cyc, bus.l_rvalid, pend == 2); end
         if (pend == 1 && !bus.f_flush) begin
            checks++; if (bus.f_rdata !== pend_data) begin failures++; $display("FAIL rand_f_rdata[%0d]: got %h expected %h", cyc, bus.f_rdata, pend_data); end
         end
         if (pend == 2) begin
            checks++; if (bus.l_rdata !== pend_data) begin failures++; $display("FAIL rand_l_rdata[%0d]: got %h expected %h", cyc, bus.l_rdata, pend_data); end
         end
         // advance the model by the operation accepted at the coming edge
         if (exp_l) begin
            if (bus.l_we) begin
               ref_mem[bus.l_addr] = bus.l_wdata;
               pend = 0;
            end else begin
               pend = 2;
               pend_data = ref_mem[bus.l_addr];
            end
         end else if (exp_f) begin
            pend = 1;
            pend_data = ref_mem[bus.f_addr];
         end else begin
            pend = 0;
         end
         if (exp_l && bus.f_req) waited = (waited < MAXB) ? waited + 1 : waited;
         else                    waited = 0;
         f_acc = exp_f;
         l_acc = exp_l;
         next_cycle();
      end
      drain();
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = mem_init(i);
      idle_inputs();
      test_reset();
      test_fetch_stream();
      test_loader_wr_rd();
      test_starvation();
      test_flush();
      test_reset_mid_read();
      test_random(600);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/imem_arbiter.md
Name: imem_arbiter

Overview:
- Shares one single-port, synchronous-read instruction memory between two requesters: the pipeline fetch port (PC-driven) and a loader/debug port that writes and reads program images.
- Sits between the fetch stage and the instruction SRAM.
- The fetch stage sees a req/gnt handshake plus a one-cycle-later read response.
- Loader has priority, bounded by a starvation guard so fetch always makes progress.

Parameters:
- DATA_WIDTH, 32, memory word width.
- IMEM_ADDR_WIDTH, 10, word address width (memory depth = 2^IMEM_ADDR_WIDTH).
- MAX_LDR_BURST, 4, maximum consecutive loader grants while fetch is waiting; legal range 1..15.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- f_req  in  1  fetch read request.
- f_addr  in  IMEM_ADDR_WIDTH  fetch word address.
- f_flush  in  1  discard the fetch response returning this cycle.
- f_gnt  out  1  fetch request accepted this cycle.
- f_rvalid  out  1  fetch read data valid.
- f_rdata  out  DATA_WIDTH  fetch read data.
- l_req  in  1  loader request.
- l_we  in  1  loader write enable (1 = write, 0 = read).
- l_addr  in  IMEM_ADDR_WIDTH  loader word address.
- l_wdata  in  DATA_WIDTH  loader write data.
- l_gnt  out  1  loader request accepted this cycle.
- l_rvalid  out  1  loader read data valid.
- l_rdata  out  DATA_WIDTH  loader read data.
- mem_en  out  1  memory access enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  IMEM_ADDR_WIDTH  memory address.
- mem_wdata  out  DATA_WIDTH  memory write data.
- mem_rdata  in  DATA_WIDTH  memory read data, valid the cycle after a read enable.

Behaviour:
- **Clock and reset:** one clock, clk. Reset is asynchronous, active-low, on rst_n.
- **Reset state:**
  - All registered state clears: response owner = NONE, burst counter = 0.
  - f_rvalid = 0, l_rvalid = 0.
  - While rst_n = 0: f_gnt, l_gnt, mem_en and mem_we are forced to 0.
- **Handshake:**
  - A transaction is accepted in a cycle where req && gnt.
  - Grants are combinational from the current-cycle requests and the registered counter.
  - At most one grant per cycle.
  - A requester must hold req, addr, we and wdata stable until granted.
- **Grant rules, evaluated each cycle:**
  - Only one requester high: that requester is granted.
  - Both high and burst_cnt < MAX_LDR_BURST: loader is granted.
  - Both high and burst_cnt == MAX_LDR_BURST: fetch is granted.
  - Neither high: no grant, mem_en = 0.
- **Burst counter** (width 4), updated on each clock edge:
  - Loader granted while f_req = 1: increment, saturating at MAX_LDR_BURST.
  - Fetch granted, or f_req = 0: reset to 0.
- **Memory drive:**
  - mem_en = f_gnt | l_gnt.
  - mem_we = l_gnt & l_we.
  - Fetch access is always a read.
  - mem_addr and mem_wdata come from the granted requester; mem_wdata = 0 when not a loader write.
- **Response routing:**
  - The owner register is set at the accepting clock edge: FETCH for a fetch read, LOADER for a loader read, NONE for a write or idle cycle.
  - In the next cycle:
    - f_rvalid = (owner == FETCH) && !f_flush.
    - l_rvalid = (owner == LOADER).
  - f_rdata and l_rdata are driven from mem_rdata at all times; their contents are meaningful only while the matching rvalid is high.
- **Latency:** read response exactly 1 cycle after acceptance. Writes have no response.
- **Throughput:** back-to-back accesses every cycle; a new grant may coincide with the previous response cycle.
- **Flush:**
  - f_flush suppresses only the response returning in the same cycle.
  - It does not block f_gnt; a fetch to the branch target may be accepted in the flush cycle and is returned normally.
- **Mid-operation reset:** an in-flight response is dropped. No rvalid pulses after reset deassertion until a new read is accepted.
- **Address range:** no bounds check; the address wraps modulo 2^IMEM_ADDR_WIDTH by width.

Test Plan:
- **Reset:** hold rst_n = 0 with f_req = l_req = 1 -> f_gnt = l_gnt = mem_en = 0, f_rvalid = l_rvalid = 0. Release -> loader granted first cycle.
- **Fetch-only stream:** f_addr = 0,1,2 on consecutive cycles, memory preloaded 0x00000013/0x00100093/0x00200113 -> f_gnt = 1 each cycle; f_rvalid with those words on cycles +1, +2, +3.
- **Loader write then read:** write 0xDEADBEEF to addr 5 (mem_we = 1, no l_rvalid), then read addr 5 -> l_rvalid = 1 and l_rdata = 0xDEADBEEF one cycle later.
- **Starvation guard** (MAX_LDR_BURST = 4, both requesting continuously) -> grant pattern L,L,L,L,F,L,L,L,L,F; burst counter returns to 0 after each fetch grant.
- **Flush:**
  - Fetch addr 3 accepted in cycle N; f_flush = 1 in N+1 with a new fetch to addr 8 accepted in N+1 -> f_rvalid = 0 in N+1, f_rvalid = 1 with mem[8] in N+2.
  - A loader read returning in the same cycle as f_flush is unaffected.
- **Reset mid-read:** loader read accepted, rst_n pulsed low before the next edge -> l_rvalid stays 0 and the owner register clears.
